// File: rtl/imm_ext_if.sv
// Bundles the instruction-side and immediate-side handshake of imm_ext_stage.
// master is the producer/consumer environment and slave is the stage itself.
interface imm_ext_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      immsel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic            out_err;
    logic [CW-1:0]   count;
    logic [7:0]      err_cnt;
    logic            clr_err;

    modport master (
        output in_valid, instr, immsel, out_ready, clr_err,
        input  in_ready, out_valid, out_imm, out_err, count, err_cnt
    );

    modport slave (
        input  in_valid, instr, immsel, out_ready, clr_err,
        output in_ready, out_valid, out_imm, out_err, count, err_cnt
    );
endinterface

// File: rtl/imm_ext_stage.sv
// Immediate-extension stage: builds the RV32I/RV64I immediate for each accepted
// instruction and queues it, with an error flag, in a small circular FIFO.
module imm_ext_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    imm_ext_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;
    logic [CW-1:0]   countQ;
    logic [7:0]      errCnt;
    logic [XLEN-1:0] immMem [DEPTH];
    logic            errMem [DEPTH];

    logic [XLEN-1:0] immNext;
    logic            errNext;
    logic            full;
    logic            push;
    logic            pop;
    logic            unusedOpcode;

    assign unusedOpcode = ^bus.instr[6:0];

    // Signed casts widen with instr[31]; unsigned casts zero-fill.
    always_comb begin
        immNext = '0;
        errNext = 1'b0;
        case (bus.immsel)
            3'b000: immNext = XLEN'($signed(bus.instr[31:20]));
            3'b001: immNext = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
            3'b010: immNext = XLEN'($signed({bus.instr[31], bus.instr[7],
                                              bus.instr[30:25], bus.instr[11:8], 1'b0}));
            3'b011: immNext = XLEN'($signed({bus.instr[31], bus.instr[19:12],
                                              bus.instr[20], bus.instr[30:21], 1'b0}));
            3'b100: immNext = XLEN'($signed({bus.instr[31:12], 12'b0}));
            3'b101: immNext = (XLEN == 64) ? XLEN'(bus.instr[25:20]) : XLEN'(bus.instr[24:20]);
            3'b110: immNext = XLEN'(bus.instr[19:15]);
            default: begin
                immNext = '0;
                errNext = 1'b1;
            end
        endcase
    end

    assign full = (countQ == CW'(DEPTH));
    assign push = bus.in_valid && !full;
    assign pop  = (countQ != '0) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            countQ <= '0;
            errCnt <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
            if (bus.clr_err) begin
                errCnt <= '0;
            end else if (push && errNext && (errCnt != 8'hFF)) begin
                errCnt <= errCnt + 1'b1;
            end
        end
    end

    // Payload storage is deliberately left out of reset; only control is flushed.
    always_ff @(posedge clk) begin
        if (push) begin
            immMem[wrPtr] <= immNext;
            errMem[wrPtr] <= errNext;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = (countQ != '0);
    assign bus.out_imm   = immMem[rdPtr];
    assign bus.out_err   = errMem[rdPtr];
    assign bus.count     = countQ;
    assign bus.err_cnt   = errCnt;
endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: one XLEN=32 and one XLEN=64 instance,
// hand-computed immediates, a small FIFO model for the full/wrap scenario.
module tb_imm_ext_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    imm_ext_if #(.XLEN(32), .DEPTH(4)) b32 ();
    imm_ext_if #(.XLEN(64), .DEPTH(4)) b64 ();

    imm_ext_stage #(.XLEN(32), .DEPTH(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_ext_stage #(.XLEN(64), .DEPTH(4)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    task automatic test_reset();
        b32.in_valid = 0; b32.instr = '0; b32.immsel = '0; b32.out_ready = 0; b32.clr_err = 0;
        b64.in_valid = 0; b64.instr = '0; b64.immsel = '0; b64.out_ready = 0; b64.clr_err = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (b32.count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", b32.count); end
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", b32.out_valid); end
        checks++; if (b32.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", b32.in_ready); end
        checks++; if (b32.err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", b32.err_cnt); end
        checks++; if (b64.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready64: got %b expected 1", b64.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_formats_32();
        logic [31:0] ins [7];
        logic [2:0]  sel [7];
        logic [31:0] exp [7];
        ins = '{32'hFFF00093, 32'hFE002E23, 32'h000000E3, 32'h0010006F, 32'h123450B7, 32'h03F01013, 32'h800F8073};
        sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        exp = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'h00000800, 32'h12345000, 32'h0000001F, 32'h0000001F};
        @(posedge clk); #1;
        b32.out_ready = 1;
        for (int k = 0; k <= 7; k++) begin
            if (k < 7) begin
                b32.in_valid = 1; b32.instr = ins[k]; b32.immsel = sel[k];
            end else begin
                b32.in_valid = 0;
            end
            @(negedge clk);
            if (k == 0) begin
                checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fmt32_latency: out_valid %b before accept, expected 0", b32.out_valid); end
            end else begin
                checks++; if (b32.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fmt32_valid[%0d]: got %b expected 1", k-1, b32.out_valid); end
                checks++; if (b32.out_imm !== exp[k-1]) begin errors++; $display("[TB] FAIL fmt32_imm[%0d]: got %h expected %h", k-1, b32.out_imm, exp[k-1]); end
                checks++; if (b32.out_err !== 1'b0) begin errors++; $display("[TB] FAIL fmt32_err[%0d]: got %b expected 0", k-1, b32.out_err); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fmt32_drain: out_valid %b expected 0", b32.out_valid); end
    endtask

    task automatic test_formats_64();
        logic [31:0] ins [7];
        logic [2:0]  sel [7];
        logic [63:0] exp [7];
        ins = '{32'h80000037, 32'h03F01013, 32'hFFF00093, 32'hFE002E23, 32'h80000063, 32'h8000006F, 32'h800F8073};
        sel = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        exp = '{64'hFFFFFFFF80000000, 64'h000000000000003F, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                64'hFFFFFFFFFFFFF000, 64'hFFFFFFFFFFF00000, 64'h000000000000001F};
        @(posedge clk); #1;
        b64.out_ready = 1;
        for (int k = 0; k <= 7; k++) begin
            if (k < 7) begin
                b64.in_valid = 1; b64.instr = ins[k]; b64.immsel = sel[k];
            end else begin
                b64.in_valid = 0;
            end
            @(negedge clk);
            if (k > 0) begin
                checks++; if (b64.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fmt64_valid[%0d]: got %b expected 1", k-1, b64.out_valid); end
                checks++; if (b64.out_imm !== exp[k-1]) begin errors++; $display("[TB] FAIL fmt64_imm[%0d]: got %h expected %h", k-1, b64.out_imm, exp[k-1]); end
                checks++; if (b64.out_err !== 1'b0) begin errors++; $display("[TB] FAIL fmt64_err[%0d]: got %b expected 0", k-1, b64.out_err); end
            end
            @(posedge clk); #1;
        end
    endtask

    // Reference queue tracks which items the FIFO must hold; in_ready is modelled from occupancy alone.
    task automatic test_back_to_back();
        int mq[$];
        int nextItem = 0;
        bit curValid;
        bit curReady;
        bit push;
        bit pop;
        @(posedge clk); #1;
        curValid = 1; curReady = 0;
        b32.in_valid = 1; b32.immsel = 3'd0; b32.instr = {12'(nextItem + 1), 20'h00013}; b32.out_ready = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            push = curValid && (mq.size() < 4);
            pop  = curReady && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(nextItem);
                nextItem++;
            end
            #1;
            curValid = (nextItem < 8);
            curReady = (cyc >= 4);
            b32.in_valid = curValid; b32.instr = {12'(nextItem + 1), 20'h00013}; b32.out_ready = curReady;
            @(negedge clk);
            checks++; if (b32.count !== 3'(mq.size())) begin errors++; $display("[TB] FAIL b2b_count[c%0d]: got %0d expected %0d", cyc, b32.count, mq.size()); end
            checks++; if (b32.in_ready !== (mq.size() < 4)) begin errors++; $display("[TB] FAIL b2b_in_ready[c%0d]: got %b expected %b", cyc, b32.in_ready, mq.size() < 4); end
            checks++; if (b32.out_valid !== (mq.size() > 0)) begin errors++; $display("[TB] FAIL b2b_out_valid[c%0d]: got %b expected %b", cyc, b32.out_valid, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++; if (b32.out_imm !== 32'(mq[0] + 1)) begin errors++; $display("[TB] FAIL b2b_order[c%0d]: got %h expected %h", cyc, b32.out_imm, 32'(mq[0] + 1)); end
            end
        end
        checks++; if (nextItem != 8) begin errors++; $display("[TB] FAIL b2b_accepted: got %0d expected 8", nextItem); end
        b32.in_valid = 0;
    endtask

    task automatic test_err_sat();
        @(posedge clk); #1;
        b32.out_ready = 1; b32.in_valid = 1; b32.immsel = 3'b111; b32.instr = 32'hFFFFFFFF;
        for (int n = 1; n <= 257; n++) begin
            @(posedge clk); #1;
            if (n == 257) b32.clr_err = 1;
            @(negedge clk);
            checks++; if (b32.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL err_valid[%0d]: got %b expected 1", n, b32.out_valid); end
            checks++; if (b32.out_err !== 1'b1) begin errors++; $display("[TB] FAIL err_flag[%0d]: got %b expected 1", n, b32.out_err); end
            checks++; if (b32.out_imm !== 32'h0) begin errors++; $display("[TB] FAIL err_imm[%0d]: got %h expected 0", n, b32.out_imm); end
            checks++; if (b32.err_cnt !== 8'((n > 255) ? 255 : n)) begin errors++; $display("[TB] FAIL err_cnt[%0d]: got %0d expected %0d", n, b32.err_cnt, (n > 255) ? 255 : n); end
        end
        @(posedge clk); #1;
        b32.clr_err = 0; b32.in_valid = 0;
        @(negedge clk);
        checks++; if (b32.err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL err_clear: got %0d expected 0", b32.err_cnt); end
        checks++; if (b32.out_err !== 1'b1) begin errors++; $display("[TB] FAIL err_last_flag: got %b expected 1", b32.out_err); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_drain: out_valid %b expected 0", b32.out_valid); end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        b32.out_ready = 0; b32.in_valid = 1; b32.immsel = 3'd0;
        for (int k = 0; k < 3; k++) begin
            b32.instr = {12'(12'h100 + k), 20'h00013};
            @(posedge clk); #1;
        end
        b32.in_valid = 0;
        @(negedge clk);
        checks++; if (b32.count !== 3'd3) begin errors++; $display("[TB] FAIL ar_prefill: got %0d expected 3", b32.count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (b32.count !== 3'd0) begin errors++; $display("[TB] FAIL ar_count: got %0d expected 0", b32.count); end
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_out_valid: got %b expected 0", b32.out_valid); end
        checks++; if (b32.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ar_in_ready: got %b expected 1", b32.in_ready); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        b32.in_valid = 1; b32.instr = 32'h7FF00013; b32.immsel = 3'd0; b32.out_ready = 0;
        @(negedge clk);
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_no_stale: out_valid %b expected 0", b32.out_valid); end
        @(posedge clk); #1;
        b32.in_valid = 0;
        @(negedge clk);
        checks++; if (b32.count !== 3'd1) begin errors++; $display("[TB] FAIL ar_first_accept: count %0d expected 1", b32.count); end
        checks++; if (b32.out_imm !== 32'h000007FF) begin errors++; $display("[TB] FAIL ar_first_imm: got %h expected 000007ff", b32.out_imm); end
        b32.out_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_drain: out_valid %b expected 0", b32.out_valid); end
    endtask

    initial begin
        test_reset();
        test_formats_32();
        test_formats_64();
        test_back_to_back();
        test_err_sat();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
